video_writeback_core: RTL and testbench

//  Write-side counterpart of the video line-fetch engine: drains one 1024-word line slot of the 16x1024x16 line RAM
//  (port B) into SDRAM through the burst write interface (burst_wr / burst_strobe / burst_ready).

---
 rtl/video_writeback_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_video_writeback_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/video_writeback_core.sv
// ---------------------------------------------------------------------------
// video_writeback_core
//
// Drains one 1024-word slot of the 16x1024x16 line RAM (port B) into SDRAM
// through the burst write interface. The vector renderer uses it to commit a
// finished scanline to the frame buffer that the line-fetch engine later
// reads back.
//
// Request flow: IDLE -> CMD (one-cycle burst_wr) -> STREAM (words go out
// through a 2-entry skid FIFO) -> WAIT_DONE (controller commit) -> IDLE.
//
// Ports
//   i_chip_clk          single clock
//   i_reset             synchronous, active-high reset
//   i_wb_start          one-cycle request pulse (accepted only when idle)
//   i_wb_slot/addr/len  request slot, SDRAM address, word count (0..1024)
//   o_wb_busy           request in progress
//   o_wb_done           one-cycle completion pulse
//   o_wb_overrun        sticky: request seen while busy
//   o_burst_wr          one-cycle burst command
//   o_burst_addr/len    burst start address / word count (held)
//   o_burst_strobe      o_burst_data valid
//   o_burst_data        write word
//   i_burst_ready       controller takes a word on strobe && ready
//   i_burst_data_done   controller has committed the whole burst
//   o_address_b         line RAM address {slot, word index}
//   o_wren_b/o_data_b/o_byteena_b  line RAM write port (clear feature)
//   i_q_b               line RAM read data, one cycle after o_address_b
//
// Build option
//   VIDEO_WB_CLEAR_EN   when defined, every word accepted by the controller
//                       is zeroed in the line RAM one cycle later. Otherwise
//                       the line RAM write port is tied off.
// ---------------------------------------------------------------------------
module video_writeback_core #(
  parameter int LINE_WORDS = 1024,
  parameter int SLOT_BITS  = 4
) (
  input  logic                  i_chip_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_start,
  input  logic [SLOT_BITS-1:0]  i_wb_slot,
  input  logic [31:0]           i_wb_addr,
  input  logic [10:0]           i_wb_len,
  output logic                  o_wb_busy,
  output logic                  o_wb_done,
  output logic                  o_wb_overrun,
  output logic                  o_burst_wr,
  output logic [31:0]           o_burst_addr,
  output logic [10:0]           o_burst_len,
  output logic                  o_burst_strobe,
  output logic [15:0]           o_burst_data,
  input  logic                  i_burst_ready,
  input  logic                  i_burst_data_done,
  output logic [SLOT_BITS+9:0]  o_address_b,
  output logic                  o_wren_b,
  output logic [15:0]           o_data_b,
  output logic [1:0]            o_byteena_b,
  input  logic [15:0]           i_q_b
);

  localparam logic [10:0] MAX_LEN = 11'(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CMD       = 2'd1,
    S_STREAM    = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [SLOT_BITS-1:0]   r_slot;
  logic [31:0]            r_burst_addr;
  logic [10:0]            r_len;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;
  logic                   r_burst_wr;

  logic [9:0]             r_rd_idx;     // next word index to read
  logic                   r_rd_done;    // all len reads issued
  logic                   r_ret;        // i_q_b carries a requested word this cycle
  logic [10:0]            r_acc_cnt;    // words accepted by the controller
  logic [15:0]            r_fifo_mem [0:1];
  logic                   r_wptr;
  logic                   r_rptr;
  logic [1:0]             r_fifo_cnt;

  logic                   w_idle_free;
  logic                   w_accept;
  logic [10:0]            w_len_clamped;
  logic                   w_pop;
  logic                   w_last_pop;
  logic [2:0]             w_occ;
  logic                   w_issue;
  logic                   w_clr;

  // Request acceptance, handshake and read-issue decisions
  always_comb begin
    w_idle_free   = (r_state == S_IDLE) && !r_done;
    w_accept      = i_wb_start && w_idle_free;
    if (i_wb_len > MAX_LEN) begin
      w_len_clamped = MAX_LEN;
    end else begin
      w_len_clamped = i_wb_len;
    end
    w_pop         = (r_fifo_cnt != 2'd0) && i_burst_ready;
    w_last_pop    = w_pop && (r_acc_cnt == (r_len - 11'd1));
    // Entries the FIFO is committed to after this cycle: a new read is only
    // issued if its word still fits even when nothing is popped next cycle.
    w_occ         = 3'(r_fifo_cnt) + 3'(r_ret) - 3'(w_pop);
    w_issue       = ((r_state == S_CMD) || (r_state == S_STREAM)) &&
                    !r_rd_done && (w_occ < 3'd2) && !w_clr;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_len_clamped != 11'd0)) begin
          w_state_next = S_CMD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CMD: begin
        w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_last_pop) begin
          w_state_next = S_WAIT_DONE;
        end else begin
          w_state_next = S_STREAM;
        end
      end
      S_WAIT_DONE: begin
        if (i_burst_data_done) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_chip_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, status flags and burst command
  always_ff @(posedge i_chip_clk) begin
    if (i_reset) begin
      r_slot       <= '0;
      r_burst_addr <= 32'd0;
      r_len        <= 11'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_burst_wr   <= 1'b0;
    end else begin
      r_burst_wr <= 1'b0;
      r_done     <= 1'b0;
      if (w_accept) begin
        r_slot       <= i_wb_slot;
        r_burst_addr <= i_wb_addr;
        r_len        <= w_len_clamped;
        r_busy       <= 1'b1;
        if (w_len_clamped == 11'd0) begin
          r_done <= 1'b1;   // empty request completes without a burst
        end else begin
          r_burst_wr <= 1'b1;
        end
      end else if ((r_state == S_WAIT_DONE) && i_burst_data_done) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end else if (r_done) begin
        r_busy <= 1'b0;     // ends the single busy cycle of an empty request
      end
      if (i_wb_start && !w_idle_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Line RAM prefetch and skid FIFO
  always_ff @(posedge i_chip_clk) begin
    if (i_reset) begin
      r_rd_idx      <= 10'd0;
      r_rd_done     <= 1'b0;
      r_ret         <= 1'b0;
      r_acc_cnt     <= 11'd0;
      r_fifo_mem[0] <= 16'd0;
      r_fifo_mem[1] <= 16'd0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_fifo_cnt    <= 2'd0;
    end else if (w_accept) begin
      r_rd_idx   <= 10'd0;
      r_rd_done  <= 1'b0;
      r_ret      <= 1'b0;
      r_acc_cnt  <= 11'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      r_ret <= w_issue;
      if (w_issue) begin
        // Hold the index at the last word instead of wrapping (len == 1024).
        if ({1'b0, r_rd_idx} == (r_len - 11'd1)) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_idx <= r_rd_idx + 10'd1;
        end
      end
      if (r_ret) begin
        r_fifo_mem[r_wptr] <= i_q_b;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr    <= ~r_rptr;
        r_acc_cnt <= r_acc_cnt + 11'd1;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(r_ret) - 2'(w_pop);
    end
  end

`ifdef VIDEO_WB_CLEAR_EN
  logic       r_clr;
  logic [9:0] r_clr_idx;

  // Zero each accepted word one cycle after its handshake
  always_ff @(posedge i_chip_clk) begin
    if (i_reset) begin
      r_clr     <= 1'b0;
      r_clr_idx <= 10'd0;
    end else begin
      r_clr <= w_pop;
      if (w_pop) begin
        r_clr_idx <= r_acc_cnt[9:0];
      end
    end
  end

  assign w_clr       = r_clr;
  assign o_address_b = r_clr ? {r_slot, r_clr_idx} : {r_slot, r_rd_idx};
  assign o_wren_b    = r_clr;
  assign o_data_b    = 16'd0;
  assign o_byteena_b = {2{r_clr}};
`else
  assign w_clr       = 1'b0;
  assign o_address_b = {r_slot, r_rd_idx};
  assign o_wren_b    = 1'b0;
  assign o_data_b    = 16'd0;
  assign o_byteena_b = 2'b00;
`endif

  assign o_wb_busy      = r_busy;
  assign o_wb_done      = r_done;
  assign o_wb_overrun   = r_overrun;
  assign o_burst_wr     = r_burst_wr;
  assign o_burst_addr   = r_burst_addr;
  assign o_burst_len    = r_len;
  assign o_burst_strobe = (r_fifo_cnt != 2'd0);
  assign o_burst_data   = r_fifo_mem[r_rptr];

endmodule

// File: tb/tb_video_writeback_core.sv
// Testbench for video_writeback_core: line RAM model with 1-cycle read
// latency, randomized burst_ready, and a reference that expects words
// 0..len-1 of the requested slot in order.
module tb_video_writeback_core;

  logic        clk = 1'b0;
  logic        reset, start, ready, data_done, ld_all;
  logic [3:0]  wslot;
  logic [31:0] waddr;
  logic [10:0] wlen;
  logic        busy, done, overrun, burst_wr, strobe, wren_b;
  logic [31:0] burst_addr;
  logic [10:0] burst_len;
  logic [15:0] bdata, data_b, q_b;
  logic [13:0] address_b;
  logic [1:0]  byteena_b;

  int          n_chk = 0;
  int          n_bad = 0;
  int unsigned seed;
  bit          wren_seen = 1'b0;
  logic [15:0] ram [0:16383];

  always #5 clk = ~clk;

  video_writeback_core dut (
    .i_chip_clk(clk), .i_reset(reset), .i_wb_start(start), .i_wb_slot(wslot),
    .i_wb_addr(waddr), .i_wb_len(wlen), .o_wb_busy(busy), .o_wb_done(done),
    .o_wb_overrun(overrun), .o_burst_wr(burst_wr), .o_burst_addr(burst_addr),
    .o_burst_len(burst_len), .o_burst_strobe(strobe), .o_burst_data(bdata),
    .i_burst_ready(ready), .i_burst_data_done(data_done),
    .o_address_b(address_b), .o_wren_b(wren_b), .o_data_b(data_b),
    .o_byteena_b(byteena_b), .i_q_b(q_b)
  );

  // Initial line RAM contents: a seeded hash of the word address
  function automatic logic [15:0] pat(input int a);
    logic [31:0] x;
    x = (32'(a) * 32'h9E37_79B1) ^ seed;
    x = x ^ (x >> 13);
    x = x * 32'h85EB_CA6B;
    return x[31:16];
  endfunction

  // Line RAM model: 1-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 16384; i++) ram[i] <= pat(i);
    end else if (wren_b) begin
      if (byteena_b[0]) ram[address_b][7:0]  <= data_b[7:0];
      if (byteena_b[1]) ram[address_b][15:8] <= data_b[15:8];
    end
    q_b <= ram[address_b];
  end

  // Records whether the line RAM write enable was ever raised
  always @(negedge clk) begin
    if (wren_b) wren_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One write-back request, driven and checked from a negedge
  task automatic do_req(input logic [3:0] slot, input logic [10:0] len, input bit rnd_ready,
                        input bit poke_mid, input bit spur_done, input bit poke_done);
    logic [31:0] addr;
    logic [15:0] got [$];
    int eff, cyc, first_cyc, last_cyc, nwr;
    bit gap_bad, poked, spurred, early_done;
    addr = $urandom;
    eff  = (len > 11'd1024) ? 1024 : int'(len);
    start = 1'b1; wslot = slot; waddr = addr; wlen = len;
    @(negedge clk);
    start = 1'b0; wslot = 4'($urandom); waddr = $urandom; wlen = 11'($urandom);
    if (eff == 0) begin
      chk("zl_done", done, 1); chk("zl_busy", busy, 1); chk("zl_bwr", burst_wr, 0);
      @(negedge clk);
      chk("zl_done_end", done, 0); chk("zl_busy_end", busy, 0); chk("zl_bwr_end", burst_wr, 0);
      return;
    end
    chk("busy", busy, 1); chk("bwr", burst_wr, 1);
    chk("baddr", burst_addr, addr); chk("blen", burst_len, eff);
    cyc = 0; first_cyc = -1; last_cyc = -1; nwr = 0;
    gap_bad = 0; poked = 0; spurred = 0; early_done = 0;
    while (got.size() < eff && cyc < 8000) begin
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (strobe && ready) begin
        got.push_back(bdata);
        if (first_cyc < 0) first_cyc = cyc;
        else if (cyc != last_cyc + 1) gap_bad = 1;
        last_cyc = cyc;
      end
      if (poke_mid && !poked && got.size() >= eff / 2) begin
        start = 1'b1; wlen = 11'd5; poked = 1;
      end
      if (spur_done && !spurred && got.size() >= eff / 4) begin
        data_done = 1'b1; spurred = 1;
      end
      @(negedge clk);
      cyc++;
      if (start) begin
        start = 1'b0;
        chk("overrun_mid", overrun, 1);
      end
      data_done = 1'b0;
      if (burst_wr) nwr++;
      if (done) early_done = 1;
    end
    chk("handshakes", got.size(), eff);
    for (int i = 0; i < got.size(); i++) chk("word", got[i], pat(int'(slot) * 1024 + i));
`ifndef VIDEO_WB_CLEAR_EN
    if (!rnd_ready) begin
      chk("first_word_lat", first_cyc, 2);
      chk("gap", gap_bad, 0);
    end
`endif
    chk("strobe_drop", strobe, 0); chk("busy_hold", busy, 1);
    chk("baddr_hold", burst_addr, addr); chk("extra_bwr", nwr, 0);
    ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("no_extra_word", strobe, 0);
      if (done) early_done = 1;
    end
    chk("early_done", early_done, 0);
    data_done = 1'b1;
    @(negedge clk);
    data_done = 1'b0;
    chk("done", done, 1); chk("busy_at_done", busy, 0);
    if (poke_done) begin
      start = 1'b1; wlen = 11'd4;
      @(negedge clk);
      start = 1'b0;
      chk("poke_busy", busy, 0); chk("poke_bwr", burst_wr, 0); chk("poke_overrun", overrun, 1);
    end else begin
      @(negedge clk);
    end
    chk("done_end", done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rslots [4];
    rslots = '{4'd8, 4'd9, 4'd12, 4'd13};
    seed = $urandom;
    reset = 1'b1; start = 1'b0; ready = 1'b0; data_done = 1'b0; ld_all = 1'b1;
    wslot = 4'd0; waddr = 32'd0; wlen = 11'd0;
    @(negedge clk);
    ld_all = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_overrun", overrun, 0);
    chk("rst_bwr", burst_wr, 0); chk("rst_blen", burst_len, 0);
    chk("rst_addr_b", address_b, 0); chk("rst_strobe", strobe, 0);
    reset = 1'b0;
    @(negedge clk);

    do_req(4'd2, 11'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("overrun_cleared", overrun, 0);
    do_req(4'd3, 11'd1024, 1'b1, 1'b0, 1'b1, 1'b0);
    do_req(4'd4, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_req(4'd6, 11'd1500, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_quiet", overrun, 0);
    do_req(4'd7, 11'd40, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      do_req(rslots[k], 11'($urandom_range(1, 64)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a stream
    wslot = 4'd10; wlen = 11'd100; waddr = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 0); chk("mr_done", done, 0); chk("mr_overrun", overrun, 0);
    chk("mr_bwr", burst_wr, 0); chk("mr_blen", burst_len, 0); chk("mr_baddr", burst_addr, 0);
    chk("mr_strobe", strobe, 0); chk("mr_bdata", bdata, 0); chk("mr_addr_b", address_b, 0);
    chk("mr_wren", wren_b, 0);
    reset = 1'b0;
    @(negedge clk);
    do_req(4'd11, 11'd16, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef VIDEO_WB_CLEAR_EN
    do_req(4'd5, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("cleared", ram[5 * 1024 + i], 0);
    chk("not_cleared", ram[5 * 1024 + 8], pat(5 * 1024 + 8));
`else
    chk("wren_never", wren_seen, 0);
    chk("ram_intact", ram[2 * 1024], pat(2 * 1024));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
